inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Streaming RV32I instruction encoder; the inverse of the decode stage.
- Accepts field-level instruction descriptions and emits 32-bit instruction words.
- Expands the LI pseudo-instruction into LUI/ADDI pairs.
- Feeds the self-test program loader and bench stimulus generators; its output stream is consumed by the instruction memory writer.

Parameters:
- CHECK_RANGE, 1, when 1 immediate range/alignment violations raise out_err; when 0 out_err is tied 0.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_fmt  input  3  enc_fmt_t: R, I, S, B, U, J, LI
- in_opcode  input  5  inst[6:2]; inst[1:0] always 2'b11
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R only)
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_imm  input  32  byte-value immediate (unshifted; U takes the full value with [11:0] zero)
- out_valid  output  1  word valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_inst  output  32  encoded instruction
- out_err  output  1  immediate violated format range/alignment (qualified by out_valid)

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_inst=0, out_err=0, FSM=IDLE. in_ready=0 while rst_n is low.
- Single-entry registered output; latency 1 cycle from accept to out_valid.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Same-cycle pop and push is allowed, giving full throughput.
- While out_valid && !out_ready: out_inst and out_err hold stable.
- Packing by format:
  - I: imm[11:0]→[31:20].
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7].
  - B: imm[12]→31, imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→7.
  - U: imm[31:12]→[31:12].
  - J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12].
  - R: funct7→[31:25].
- Register fields are inserted only where the format has them; unused fields are 0.
- Range checks (CHECK_RANGE=1):
  - I/S: imm must equal sext(imm[11:0]).
  - B: imm must equal sext(imm[12:0]) and imm[0]==0.
  - J: imm must equal sext(imm[20:0]) and imm[0]==0.
  - U: imm[11:0]==0.
- On a range violation the truncated encoding is still emitted with out_err=1.
- LI (in_opcode, in_funct3, in_rs1 ignored):
  - If imm == sext(imm[11:0]): one word, ADDI rd,x0,imm.
  - Otherwise hi=(imm+32'h800)>>12 (mod 2^32) and lo=imm-(hi<<12).
  - Emit LUI rd,hi. If lo!=0, follow with ADDI rd,rd,lo[11:0].
  - LI never sets out_err.
- FSM:
  - IDLE→LI2 on accepting an LI that needs two words. The pending rd and lo are latched in this transition.
  - In LI2, in_ready=0. When the output slot frees (!out_valid || out_ready), load ADDI and go to IDLE.
- rst_n asserted mid-LI: the pending ADDI is discarded and no partial state survives.
- Unused enc_fmt_t code: emit 32'h0, out_err=1.

Decomposition:
- Package rv_enc_pkg holds:
  - enc_fmt_t enum.
  - Opcode constants OP_IMM=5'b00100, LUI=5'b01101, plus the other base opcodes.
  - Format bit-slice widths.
- Sub-module inst_pack: purely combinational packer, (fmt, fields, imm) → {inst, err}. It is reused for both the normal path and the LI second word.
- inst_encoder holds the handshake, output register and FSM.

Test Plan:
- ADDI (fmt=I, opcode=00100, funct3=0, rd=1, rs1=0, imm=5) → 0x00500093 one cycle after accept, out_err=0.
- LI rd=5 imm=0x12345678, out_ready=1 → 0x123452B7 then 0x67828293 on consecutive cycles; in_ready=0 for one cycle.
- LI rd=1, imm=0xFFF → 0x000010B7, 0xFFF08093. LI rd=1, imm=0x00010000 → single word 0x000100B7.
- JAL (fmt=J, opcode=11011, rd=1, imm=8) → 0x008000EF. BEQ with imm=3 → out_err=1. I-format with imm=0x800 → out_err=1.
- Backpressure: out_ready=0 for 3 cycles after out_valid → out_inst stable, in_ready=0. Release → word consumed and the next request accepted in the same cycle.
- Assert rst_n low while in LI2 → out_valid=0 immediately. After release, no ADDI is emitted and the next request encodes normally.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package rv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_LI = 3'd6
  } enc_fmt_t;

  localparam int unsigned INST_W = 32;
  localparam int unsigned OPC_W  = 5;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;
  localparam int unsigned LO_W   = 12;

  // Signed widths of the immediate each format can carry.
  localparam int unsigned IMM_I_W = 12;
  localparam int unsigned IMM_B_W = 13;
  localparam int unsigned IMM_J_W = 21;

  localparam logic [OPC_W-1:0] OP_LOAD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_IMM    = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_STORE  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_OP     = 5'b01100;
  localparam logic [OPC_W-1:0] OP_LUI    = 5'b01101;
  localparam logic [OPC_W-1:0] OP_BRANCH = 5'b11000;
  localparam logic [OPC_W-1:0] OP_JALR   = 5'b11001;
  localparam logic [OPC_W-1:0] OP_JAL    = 5'b11011;
  localparam logic [OPC_W-1:0] OP_SYSTEM = 5'b11100;

  // True when v equals the sign extension of its low w bits.
  function automatic logic fits_signed(input logic [INST_W-1:0] v, input int unsigned w);
    logic [INST_W-1:0] ext;
    ext = INST_W'($signed(v) >>> (w - 1));
    return (ext == '0) || (ext == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bundle between an instruction source and the encoder.
interface inst_encoder_if;
  import rv_enc_pkg::*;

  logic                in_valid;
  logic                in_ready;
  enc_fmt_t            in_fmt;
  logic [OPC_W-1:0]    in_opcode;
  logic [F3_W-1:0]     in_funct3;
  logic [F7_W-1:0]     in_funct7;
  logic [REG_W-1:0]    in_rd;
  logic [REG_W-1:0]    in_rs1;
  logic [REG_W-1:0]    in_rs2;
  logic [INST_W-1:0]   in_imm;
  logic                out_valid;
  logic                out_ready;
  logic [INST_W-1:0]   out_inst;
  logic                out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/inst_pack.sv
// Combinational RV32I field packer with immediate range/alignment check.
module inst_pack
  import rv_enc_pkg::*;
#(
  parameter int unsigned CHECK_RANGE = 1
) (
  input  enc_fmt_t            fmt,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [F3_W-1:0]     funct3,
  input  logic [F7_W-1:0]     funct7,
  input  logic [REG_W-1:0]    rd,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rs2,
  input  logic [INST_W-1:0]   imm,
  output logic [INST_W-1:0]   inst_c,
  output logic                err_c
);

  logic [6:0] op7;
  logic       viol;

  assign op7 = {opcode, 2'b11};

  always_comb begin
    inst_c = '0;
    viol   = 1'b0;
    case (fmt)
      FMT_R: inst_c = {funct7, rs2, rs1, funct3, rd, op7};
      FMT_I: begin
        inst_c = {imm[11:0], rs1, funct3, rd, op7};
        viol   = !fits_signed(imm, IMM_I_W);
      end
      FMT_S: begin
        inst_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], op7};
        viol   = !fits_signed(imm, IMM_I_W);
      end
      FMT_B: begin
        inst_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op7};
        viol   = !fits_signed(imm, IMM_B_W) || imm[0];
      end
      FMT_U: begin
        inst_c = {imm[31:12], rd, op7};
        viol   = (imm[11:0] != '0);
      end
      FMT_J: begin
        inst_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op7};
        viol   = !fits_signed(imm, IMM_J_W) || imm[0];
      end
      // LI is expanded upstream; it and the spare code are illegal here.
      default: viol = 1'b1;
    endcase
    err_c = (CHECK_RANGE != 0) ? viol : 1'b0;
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder: handshake, single-entry output register, LI expansion.
module inst_encoder
  import rv_enc_pkg::*;
#(
  parameter int unsigned CHECK_RANGE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  inst_encoder_if.slave  bus
);

  typedef enum logic {ST_IDLE, ST_LI2} state_t;

  state_t              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [INST_W-1:0]   out_inst_q, out_inst_d;
  logic                out_err_q, out_err_d;
  logic [REG_W-1:0]    pend_rd_q, pend_rd_d;
  logic [LO_W-1:0]     pend_lo_q, pend_lo_d;

  logic                slot_free_c, accept_c, is_li_c, li_small_c, li_two_c;
  logic [INST_W-1:0]   li_sum_c;
  enc_fmt_t            p_fmt;
  logic [OPC_W-1:0]    p_opcode;
  logic [F3_W-1:0]     p_funct3;
  logic [F7_W-1:0]     p_funct7;
  logic [REG_W-1:0]    p_rd, p_rs1, p_rs2;
  logic [INST_W-1:0]   p_imm, p_inst_c;
  logic                p_err_c;

  assign slot_free_c = !out_valid_q || bus.out_ready;
  assign bus.in_ready = rst_n && (state_q == ST_IDLE) && slot_free_c;
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_err   = out_err_q;

  // LI split: lo keeps imm[11:0] (sign-extended later), hi absorbs the rounding carry.
  assign is_li_c    = (bus.in_fmt == FMT_LI);
  assign li_sum_c   = bus.in_imm + 32'h0000_0800;
  assign li_small_c = fits_signed(bus.in_imm, IMM_I_W);
  assign li_two_c   = !li_small_c && (bus.in_imm[11:0] != '0);

  // Packer input select: pending ADDI, LI first word, or the request as given.
  always_comb begin
    p_fmt    = bus.in_fmt;
    p_opcode = bus.in_opcode;
    p_funct3 = bus.in_funct3;
    p_funct7 = bus.in_funct7;
    p_rd     = bus.in_rd;
    p_rs1    = bus.in_rs1;
    p_rs2    = bus.in_rs2;
    p_imm    = bus.in_imm;
    if (state_q == ST_LI2) begin
      p_fmt    = FMT_I;
      p_opcode = OP_IMM;
      p_funct3 = '0;
      p_funct7 = '0;
      p_rd     = pend_rd_q;
      p_rs1    = pend_rd_q;
      p_rs2    = '0;
      p_imm    = {{(INST_W-LO_W){pend_lo_q[LO_W-1]}}, pend_lo_q};
    end else if (is_li_c) begin
      p_funct3 = '0;
      p_funct7 = '0;
      p_rs1    = '0;
      p_rs2    = '0;
      if (li_small_c) begin
        p_fmt    = FMT_I;
        p_opcode = OP_IMM;
      end else begin
        p_fmt    = FMT_U;
        p_opcode = OP_LUI;
        p_imm    = {li_sum_c[31:12], 12'h000};
      end
    end
  end

  inst_pack #(.CHECK_RANGE(CHECK_RANGE)) u_pack (
    .fmt    (p_fmt),
    .opcode (p_opcode),
    .funct3 (p_funct3),
    .funct7 (p_funct7),
    .rd     (p_rd),
    .rs1    (p_rs1),
    .rs2    (p_rs2),
    .imm    (p_imm),
    .inst_c (p_inst_c),
    .err_c  (p_err_c)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    pend_rd_d   = pend_rd_q;
    pend_lo_d   = pend_lo_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          out_valid_d = 1'b1;
          out_inst_d  = p_inst_c;
          out_err_d   = p_err_c && !is_li_c;
          if (is_li_c && li_two_c) begin
            state_d   = ST_LI2;
            pend_rd_d = bus.in_rd;
            pend_lo_d = bus.in_imm[LO_W-1:0];
          end
        end
      end
      ST_LI2: begin
        if (slot_free_c) begin
          out_valid_d = 1'b1;
          out_inst_d  = p_inst_c;
          out_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_err_q   <= 1'b0;
      pend_rd_q   <= '0;
      pend_lo_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      pend_rd_q   <= pend_rd_d;
      pend_lo_q   <= pend_lo_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: vector table, directed corner sequences, random scoreboard.
module tb_inst_encoder;
  import rv_enc_pkg::*;

  localparam int F_R = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5, F_LI = 6;

  typedef struct {
    logic [2:0]  fmt;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    req_t        req;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_encoder_if bus();
  inst_encoder #(.CHECK_RANGE(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          n_vec = 0;
  int          n_err = 0;
  word_t       exp_q[$];
  vec_t        tbl[$];
  req_t        cur;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_inst;
  logic        stall_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input int fmt, input int op, input int f3, input int f7,
                              input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    req_t r;
    r.fmt = 3'(fmt); r.op = 5'(op); r.f3 = 3'(f3); r.f7 = 7'(f7);
    r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = imm;
    return r;
  endfunction

  // Take n bits of v starting at lsb and place them at bit dst.
  function automatic logic [31:0] fld(input logic [31:0] v, input int lsb, input int n, input int dst);
    return ((v >> lsb) & ((32'd1 << n) - 32'd1)) << dst;
  endfunction

  function automatic logic [31:0] addi_w(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return fld(imm, 0, 12, 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
  endfunction

  task automatic push(input logic [31:0] inst, input logic err);
    word_t w;
    w.inst = inst; w.err = err;
    exp_q.push_back(w);
  endtask

  // Reference model: the words a request should produce, from the ISA field layout.
  task automatic model(input req_t r);
    longint      s;
    logic [31:0] regs, opw, hi, lo;
    s    = longint'($signed(r.imm));
    opw  = (32'(r.op) << 2) | 32'd3;
    regs = (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12);
    case (int'(r.fmt))
      F_R: push((32'(r.f7) << 25) | regs | (32'(r.rd) << 7) | opw, 1'b0);
      F_I: push(fld(r.imm, 0, 12, 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12) | (32'(r.rd) << 7) | opw,
                s < -2048 || s > 2047);
      F_S: push(fld(r.imm, 5, 7, 25) | regs | fld(r.imm, 0, 5, 7) | opw, s < -2048 || s > 2047);
      F_B: push(fld(r.imm, 12, 1, 31) | fld(r.imm, 5, 6, 25) | regs | fld(r.imm, 1, 4, 8) |
                fld(r.imm, 11, 1, 7) | opw, s < -4096 || s > 4095 || (r.imm % 2) != 0);
      F_U: push((r.imm & 32'hFFFFF000) | (32'(r.rd) << 7) | opw, (r.imm % 4096) != 0);
      F_J: push(fld(r.imm, 20, 1, 31) | fld(r.imm, 1, 10, 21) | fld(r.imm, 11, 1, 20) |
                fld(r.imm, 12, 8, 12) | (32'(r.rd) << 7) | opw,
                s < -1048576 || s > 1048575 || (r.imm % 2) != 0);
      F_LI: begin
        if (s >= -2048 && s <= 2047) push(addi_w(r.rd, 5'd0, r.imm), 1'b0);
        else begin
          hi = (r.imm + 32'h800) >> 12;
          lo = r.imm - (hi << 12);
          push((hi << 12) | (32'(r.rd) << 7) | 32'h37, 1'b0);
          if (lo != 0) push(addi_w(r.rd, r.rd, lo), 1'b0);
        end
      end
      default: push(32'h0, 1'b1);
    endcase
  endtask

  task automatic drive(input req_t r);
    bus.in_fmt    = enc_fmt_t'(r.fmt);
    bus.in_opcode = r.op;
    bus.in_funct3 = r.f3;
    bus.in_funct7 = r.f7;
    bus.in_rd     = r.rd;
    bus.in_rs1    = r.rs1;
    bus.in_rs2    = r.rs2;
    bus.in_imm    = r.imm;
  endtask

  // Present a request until accepted (bounded); returns at posedge+1 after the accepting edge.
  task automatic send(input req_t r, input string name);
    logic got;
    got = 1'b0;
    drive(r);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check({name, "_accept"}, 32'(got), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One random-phase cycle: scoreboard pop, hold check and model push all at negedge.
  task automatic cycle();
    word_t w;
    @(negedge clk);
    if (stall_prev && bus.out_valid) begin
      check("hold_inst", bus.out_inst, stall_inst);
      check("hold_err", 32'(bus.out_err), 32'(stall_err));
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("sb_extra_word", 32'(exp_q.size()), 32'd1);
      else begin
        w = exp_q.pop_front();
        check("sb_inst", bus.out_inst, w.inst);
        check("sb_err", 32'(bus.out_err), 32'(w.err));
      end
    end
    if (bus.in_valid && bus.in_ready) model(cur);
    stall_prev = bus.out_valid && !bus.out_ready;
    stall_inst = bus.out_inst;
    stall_err  = bus.out_err;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 4095)) - 32'd2048;
      1:       return r;
      2:       return r & 32'hFFFFF000;
      3:       return {{19{r[12]}}, r[12:0]};
      default: return {{11{r[20]}}, r[20:0]};
    endcase
  endfunction

  task automatic add(input req_t r, input logic [31:0] inst, input logic err);
    vec_t v;
    v.req = r; v.inst = inst; v.err = err;
    tbl.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(mk(F_I, 0, 0, 0, 0, 0, 0, 32'h0));

    add(mk(F_I, 5'b00100, 0, 0, 1, 0, 0, 32'd5),        32'h00500093, 1'b0);
    add(mk(F_J, 5'b11011, 0, 0, 1, 0, 0, 32'd8),        32'h008000EF, 1'b0);
    add(mk(F_B, 5'b11000, 0, 0, 0, 0, 0, 32'd3),        32'h00000163, 1'b1);
    add(mk(F_I, 5'b00100, 0, 0, 1, 0, 0, 32'h800),      32'h80000093, 1'b1);
    add(mk(F_R, 5'b01100, 0, 0, 3, 1, 2, 32'h0),        32'h002081B3, 1'b0);
    add(mk(F_R, 5'b01100, 0, 7'h20, 3, 1, 2, 32'h0),    32'h402081B3, 1'b0);
    add(mk(F_S, 5'b01000, 2, 0, 0, 1, 2, 32'd8),        32'h0020A423, 1'b0);
    add(mk(F_U, 5'b01101, 0, 0, 1, 0, 0, 32'h12345000), 32'h123450B7, 1'b0);
    add(mk(F_U, 5'b01101, 0, 0, 1, 0, 0, 32'h12345001), 32'h123450B7, 1'b1);
    add(mk(F_B, 5'b11000, 0, 0, 0, 0, 0, 32'hFFFFFFFC), 32'hFE000EE3, 1'b0);
    add(mk(7,   5'b00100, 0, 0, 1, 1, 1, 32'h5),        32'h00000000, 1'b1);
    add(mk(F_J, 5'b11011, 0, 0, 1, 0, 0, 32'd9),        32'h008000EF, 1'b1);
    add(mk(F_I, 5'b00100, 0, 0, 1, 0, 0, 32'hFFFFF800), 32'h80000093, 1'b0);
    add(mk(F_B, 5'b11000, 0, 0, 0, 0, 0, 32'd4096),     32'h80000063, 1'b1);
    add(mk(F_B, 5'b11000, 0, 0, 0, 0, 0, 32'd4094),     32'h7E000FE3, 1'b0);
    add(mk(F_S, 5'b01000, 2, 0, 0, 0, 0, 32'd2048),     32'h80002023, 1'b1);
    add(mk(F_J, 5'b11011, 0, 0, 1, 0, 0, 32'h00100000), 32'h800000EF, 1'b1);
    add(mk(F_J, 5'b11011, 0, 0, 0, 0, 0, 32'hFFFFFFFE), 32'hFFFFF06F, 1'b0);

    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single-word vectors, one cycle latency from accept.
    bus.out_ready = 1'b1;
    foreach (tbl[i]) begin
      send(tbl[i].req, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_inst", i), bus.out_inst, tbl[i].inst);
      check($sformatf("vec%0d_err", i), 32'(bus.out_err), 32'(tbl[i].err));
    end
    step();
    check("idle_valid", 32'(bus.out_valid), 32'd0);

    // LI two-word expansion.
    send(mk(F_LI, 3, 7, 0, 5, 9, 0, 32'h12345678), "li1");
    check("li1_lui", bus.out_inst, 32'h123452B7);
    check("li1_busy", 32'(bus.in_ready), 32'd0);
    step();
    check("li1_addi", bus.out_inst, 32'h67828293);
    check("li1_addi_valid", 32'(bus.out_valid), 32'd1);
    check("li1_ready_back", 32'(bus.in_ready), 32'd1);
    send(mk(F_LI, 0, 0, 0, 1, 0, 0, 32'h00000FFF), "li2");
    check("li2_lui", bus.out_inst, 32'h000010B7);
    step();
    check("li2_addi", bus.out_inst, 32'hFFF08093);
    send(mk(F_LI, 0, 0, 0, 1, 0, 0, 32'h00010000), "li3");
    check("li3_lui", bus.out_inst, 32'h000100B7);
    check("li3_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("li3_single", 32'(bus.out_valid), 32'd0);

    // Backpressure: word held, next request stalled, then accepted on release.
    bus.out_ready = 1'b0;
    send(mk(F_I, 5'b00100, 0, 0, 1, 0, 0, 32'd5), "bp1");
    drive(mk(F_R, 5'b01100, 0, 0, 3, 1, 2, 32'h0));
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_inst", bus.out_inst, 32'h00500093);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("bp_next_inst", bus.out_inst, 32'h002081B3);
    check("bp_next_valid", 32'(bus.out_valid), 32'd1);
    step();

    // Reset while the ADDI half of an LI is pending.
    bus.out_ready = 1'b0;
    send(mk(F_LI, 0, 0, 0, 5, 0, 0, 32'h12345678), "rli");
    check("rli_lui", bus.out_inst, 32'h123452B7);
    #2 rst_n = 1'b0;
    #1;
    check("rli_valid_low", 32'(bus.out_valid), 32'd0);
    check("rli_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("rli_no_addi", 32'(bus.out_valid), 32'd0);
      step();
    end
    send(mk(F_I, 5'b00100, 0, 0, 1, 0, 0, 32'd5), "rli_next");
    check("rli_next_inst", bus.out_inst, 32'h00500093);
    check("rli_next_err", 32'(bus.out_err), 32'd0);
    step();

    // Random traffic against the reference model.
    exp_q.delete();
    stall_prev = 1'b0;
    for (int c = 0; c < 600; c++) begin
      cur = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 127)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), rand_imm());
      drive(cur);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) cycle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
